// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } pri_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: req[0]/grant[0] is requester A, req[1]/grant[1] is requester B.
module rr_arb2
   import rf_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0]  req,
   input  pri_state_t  state,
   output logic [1:0]  grant,
   output pri_state_t  next_state
);

   // Only a real contention consults the priority state; a lone request always wins.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         if (FIXED_PRIO != 0 || state == PRI_B) begin
            grant = 2'b10;
         end else begin
            grant = 2'b01;
         end
      end
   end

   always_comb begin
      next_state = state;
      if (grant[0]) begin
         next_state = PRI_B;
      end else if (grant[1]) begin
         next_state = PRI_A;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port.
module reg_wb_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIXED_PRIO = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   input  logic [ADDR_W-1:0]    a_reg,
   input  logic [DATA_W-1:0]    a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [ADDR_W-1:0]    b_reg,
   input  logic [DATA_W-1:0]    b_data,
   output logic                 b_ready,
   output logic                 reg_write,
   output logic [ADDR_W-1:0]    write_reg,
   output logic [DATA_W-1:0]    write_data,
   output logic [2**ADDR_W-1:0] busy,
   output logic [15:0]          conflict_cnt
);

   pri_state_t              state;
   pri_state_t              next_state;
   logic       [1:0]        req;
   logic       [1:0]        grant;
   logic       [ADDR_W-1:0] sel_reg;
   logic       [DATA_W-1:0] sel_data;

   // Requests are masked during reset so nothing is accepted while rst is high.
   assign req     = {b_valid & ~rst, a_valid & ~rst};
   assign a_ready = grant[0];
   assign b_ready = grant[1];

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .req        (req),
      .state      (state),
      .grant      (grant),
      .next_state (next_state)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PRI_B;
      end else begin
         state <= next_state;
      end
   end

   assign sel_reg  = grant[1] ? b_reg  : a_reg;
   assign sel_data = grant[1] ? b_data : a_data;

   // Writes to register 0 are swallowed; the data path still captures them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else if (|grant) begin
         reg_write  <= (sel_reg != '0);
         write_reg  <= sel_reg;
         write_data <= sel_data;
      end else begin
         reg_write  <= 1'b0;
      end
   end

   always_comb begin
      busy = '0;
      if (reg_write) begin
         busy[write_reg] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (a_valid && b_valid && conflict_cnt != 16'hFFFF) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_reg_wb_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid;
   logic [ADDR_W-1:0] a_reg;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic [ADDR_W-1:0] b_reg;
   logic [DATA_W-1:0] b_data;

   logic              a_ready, b_ready, reg_write;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [31:0]       busy;
   logic [15:0]       conflict_cnt;

   logic              fp_a_ready, fp_b_ready, fp_reg_write;
   logic [ADDR_W-1:0] fp_write_reg;
   logic [DATA_W-1:0] fp_write_data;
   logic [31:0]       fp_busy;
   logic [15:0]       fp_conflict_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .busy(busy), .conflict_cnt(conflict_cnt)
   );

   reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(fp_a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(fp_b_ready),
      .reg_write(fp_reg_write), .write_reg(fp_write_reg), .write_data(fp_write_data),
      .busy(fp_busy), .conflict_cnt(fp_conflict_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] ar,
                                input logic [DATA_W-1:0] ad, input logic bv,
                                input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd);
      a_valid = av;
      a_reg   = ar;
      a_data  = ad;
      b_valid = bv;
      b_reg   = br;
      b_data  = bd;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      // Requests during reset must be refused
      applyStimulus(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
      #1;
      checkOutput("rst_a_ready", a_ready, 0);
      checkOutput("rst_b_ready", b_ready, 0);
      @(posedge clk); #1;
      checkOutput("rst_reg_write", reg_write, 0);
      checkOutput("rst_write_reg", write_reg, 0);
      checkOutput("rst_write_data", write_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_conflict", conflict_cnt, 0);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b0;

      // Single ALU write, latency 1
      @(negedge clk);
      applyStimulus(1'b1, 5'd10, 32'd99, 1'b0, '0, '0);
      #1;
      checkOutput("single_a_ready", a_ready, 1);
      checkOutput("single_b_ready", b_ready, 0);
      @(posedge clk); #1;
      checkOutput("single_reg_write", reg_write, 1);
      checkOutput("single_write_reg", write_reg, 10);
      checkOutput("single_write_data", write_data, 99);
      checkOutput("single_busy", busy, 64'h400);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;
      checkOutput("idle_reg_write", reg_write, 0);
      checkOutput("idle_write_reg_hold", write_reg, 10);
      checkOutput("idle_write_data_hold", write_data, 99);
      checkOutput("idle_busy", busy, 0);

      // Conflict after reset: B first, then A, then B again
      doReset();
      applyStimulus(1'b1, 5'd9, 32'd777, 1'b1, 5'd8, 32'd123);
      #1;
      checkOutput("c1_b_ready", b_ready, 1);
      checkOutput("c1_a_ready", a_ready, 0);
      checkOutput("c1_fp_b_ready", fp_b_ready, 1);
      @(posedge clk); #1;
      checkOutput("c1_write_reg", write_reg, 8);
      checkOutput("c1_write_data", write_data, 123);
      checkOutput("c1_reg_write", reg_write, 1);
      @(negedge clk); #1;
      checkOutput("c2_a_ready", a_ready, 1);
      checkOutput("c2_b_ready", b_ready, 0);
      checkOutput("c2_fp_a_ready", fp_a_ready, 0);
      checkOutput("c2_fp_b_ready", fp_b_ready, 1);
      @(posedge clk); #1;
      checkOutput("c2_write_reg", write_reg, 9);
      checkOutput("c2_write_data", write_data, 777);
      checkOutput("c2_conflict", conflict_cnt, 2);
      checkOutput("c2_fp_write_reg", fp_write_reg, 8);
      @(negedge clk); #1;
      checkOutput("c3_b_ready", b_ready, 1);
      checkOutput("c3_fp_a_ready", fp_a_ready, 0);
      checkOutput("c3_fp_b_ready", fp_b_ready, 1);
      @(posedge clk); #1;
      checkOutput("c3_conflict", conflict_cnt, 3);
      checkOutput("c3_fp_conflict", fp_conflict_cnt, 3);
      checkOutput("c3_fp_write_data", fp_write_data, 123);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;
      checkOutput("c4_conflict_hold", conflict_cnt, 3);

      // Destination 0 is consumed without a write
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'd444);
      #1;
      checkOutput("r0_b_ready", b_ready, 1);
      @(posedge clk); #1;
      checkOutput("r0_reg_write", reg_write, 0);
      checkOutput("r0_busy", busy, 0);

      // Reset mid-flight drops the pending write asynchronously
      @(negedge clk);
      applyStimulus(1'b1, 5'd11, 32'd907, 1'b0, '0, '0);
      #1;
      checkOutput("ar_a_ready", a_ready, 1);
      @(posedge clk); #1;
      checkOutput("ar_reg_write_pre", reg_write, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_reg_write", reg_write, 0);
      checkOutput("ar_busy", busy, 0);
      checkOutput("ar_conflict", conflict_cnt, 0);
      checkOutput("ar_a_ready_in_rst", a_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;
      checkOutput("ar_no_write", reg_write, 0);
      checkOutput("ar_write_reg", write_reg, 0);

      // Same register, A then B: both committed in order
      @(negedge clk);
      applyStimulus(1'b1, 5'd22, 32'd399, 1'b0, '0, '0);
      @(posedge clk); #1;
      checkOutput("same_w1_reg", write_reg, 22);
      checkOutput("same_w1_data", write_data, 399);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd22, 32'd500);
      #1;
      checkOutput("same_b_ready", b_ready, 1);
      @(posedge clk); #1;
      checkOutput("same_w2_write", reg_write, 1);
      checkOutput("same_w2_reg", write_reg, 22);
      checkOutput("same_w2_data", write_data, 500);
      checkOutput("same_w2_busy", busy, 64'h0040_0000);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
